vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, the next generation of the fixed 640x480 sync generator. Produces sync, blank, active-area, coordinate and frame/line-start signals for any mode set by parameters. A pixel-clock enable lets it run from a faster system clock. Every output is registered on a single clock edge. Sits between the clock/reset block and the pixel-rendering logic (paddle and ball drawing), and gates that logic's video bit.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, blank, active, coordinates, line/frame pulses.
// Optional line-compare interrupt built when VGA_LINE_IRQ_EN is defined.
module vga_timing_gen #(
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CW         = 10
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic          i_PixEn,
  input  logic          i_Video,
`ifdef VGA_LINE_IRQ_EN
  input  logic [CW-1:0] i_IrqLine,
  output logic          o_LineIrq,
`endif
  output logic [CW-1:0] o_X,
  output logic [CW-1:0] o_Y,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_HBlank,
  output logic          o_VBlank,
  output logic          o_Active,
  output logic          o_LineStart,
  output logic          o_FrameStart,
  output logic          o_Video
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CW-1:0] x_nxt, y_nxt;
  logic          hs_on, vs_on, line_entry, frame_entry;

  // Decodes come from the next position so they register alongside o_X/o_Y.
  always_comb begin
    x_nxt = (o_X == H_LAST) ? '0 : o_X + ONE;
    y_nxt = o_Y;
    if (o_X == H_LAST)
      y_nxt = (o_Y == V_LAST) ? '0 : o_Y + ONE;
  end

  assign hs_on       = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
  assign vs_on       = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
  assign line_entry  = i_PixEn && (x_nxt == '0);
  assign frame_entry = line_entry && (y_nxt == '0);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_X          <= H_LAST;
      o_Y          <= V_LAST;
      o_HSync      <= ~H_SYNC_POL;
      o_VSync      <= ~V_SYNC_POL;
      o_HBlank     <= 1'b1;
      o_VBlank     <= 1'b1;
      o_Active     <= 1'b0;
      o_LineStart  <= 1'b0;
      o_FrameStart <= 1'b0;
      o_Video      <= 1'b0;
    end else begin
      // Pulses fall on the next clock regardless of the enable.
      o_LineStart  <= line_entry;
      o_FrameStart <= frame_entry;
      if (i_PixEn) begin
        o_X      <= x_nxt;
        o_Y      <= y_nxt;
        o_HSync  <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
        o_VSync  <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
        o_HBlank <= (x_nxt >= H_VIS);
        o_VBlank <= (y_nxt >= V_VIS);
        o_Active <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
        o_Video  <= i_Video & o_Active;
      end
    end
  end

`ifdef VGA_LINE_IRQ_EN
  // Lines >= V_TOTAL are never reached by y, so such compare values never fire.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) o_LineIrq <= 1'b0;
    else         o_LineIrq <= line_entry && (y_nxt == i_IrqLine);
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance and a tiny 15x13 mode instance
// sharing clock, reset and enable; a reference raster model tracks both.
module tb_vga_timing_gen;
  // tiny mode: H 8+2+3+2 = 15, V 6+2+2+3 = 13, hsync active-high, vsync active-low
  localparam int D_HT = 640 + 16 + 96 + 48;
  localparam int D_VT = 480 + 10 + 2 + 33;
  localparam int S_HT = 8 + 2 + 3 + 2;
  localparam int S_VT = 6 + 2 + 2 + 3;
  localparam int D_CW = 10;
  localparam int S_CW = 5;

  logic gclk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  logic vin = 1'b0;
  always #5 gclk = ~gclk;

  logic [D_CW-1:0] d_x, d_y;
  logic [S_CW-1:0] s_x, s_y;
  logic d_hs, d_vs, d_hb, d_vb, d_act, d_ls, d_fs, d_vid;
  logic s_hs, s_vs, s_hb, s_vb, s_act, s_ls, s_fs, s_vid;
`ifdef VGA_LINE_IRQ_EN
  logic [D_CW-1:0] d_irq_line = 10'd600;
  logic [S_CW-1:0] s_irq_line = 5'd3;
  logic d_irq, s_irq;
`endif

  vga_timing_gen dut (
    .i_Clk(gclk), .i_Reset(rst), .i_PixEn(pix_en), .i_Video(vin),
`ifdef VGA_LINE_IRQ_EN
    .i_IrqLine(d_irq_line), .o_LineIrq(d_irq),
`endif
    .o_X(d_x), .o_Y(d_y), .o_HSync(d_hs), .o_VSync(d_vs), .o_HBlank(d_hb), .o_VBlank(d_vb),
    .o_Active(d_act), .o_LineStart(d_ls), .o_FrameStart(d_fs), .o_Video(d_vid)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CW(S_CW)
  ) dut_s (
    .i_Clk(gclk), .i_Reset(rst), .i_PixEn(pix_en), .i_Video(vin),
`ifdef VGA_LINE_IRQ_EN
    .i_IrqLine(s_irq_line), .o_LineIrq(s_irq),
`endif
    .o_X(s_x), .o_Y(s_y), .o_HSync(s_hs), .o_VSync(s_vs), .o_HBlank(s_hb), .o_VBlank(s_vb),
    .o_Active(s_act), .o_LineStart(s_ls), .o_FrameStart(s_fs), .o_Video(s_vid)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  int ex, ey, sx, sy;
  logic evid, svid, els, efs, sls, sfs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic hb, vb;
    hb = (ex >= 640); vb = (ey >= 480);
    chk("d_x", 32'(d_x), 32'(ex));
    chk("d_y", 32'(d_y), 32'(ey));
    chk("d_hblank", 32'(d_hb), 32'(hb));
    chk("d_vblank", 32'(d_vb), 32'(vb));
    chk("d_active", 32'(d_act), 32'(!hb && !vb));
    chk("d_hsync", 32'(d_hs), 32'(!(ex >= 656 && ex <= 751)));
    chk("d_vsync", 32'(d_vs), 32'(!(ey >= 490 && ey <= 491)));
    chk("d_linestart", 32'(d_ls), 32'(els));
    chk("d_framestart", 32'(d_fs), 32'(efs));
    chk("d_video", 32'(d_vid), 32'(evid));
    hb = (sx >= 8); vb = (sy >= 6);
    chk("s_x", 32'(s_x), 32'(sx));
    chk("s_y", 32'(s_y), 32'(sy));
    chk("s_hblank", 32'(s_hb), 32'(hb));
    chk("s_vblank", 32'(s_vb), 32'(vb));
    chk("s_active", 32'(s_act), 32'(!hb && !vb));
    chk("s_hsync", 32'(s_hs), 32'(sx >= 10 && sx <= 12));
    chk("s_vsync", 32'(s_vs), 32'(!(sy >= 8 && sy <= 9)));
    chk("s_linestart", 32'(s_ls), 32'(sls));
    chk("s_framestart", 32'(s_fs), 32'(sfs));
    chk("s_video", 32'(s_vid), 32'(svid));
`ifdef VGA_LINE_IRQ_EN
    chk("d_lineirq", 32'(d_irq), 32'(els && ey == int'(d_irq_line)));
    chk("s_lineirq", 32'(s_irq), 32'(sls && sy == int'(s_irq_line)));
`endif
  endtask

  task automatic model_reset();
    ex = D_HT - 1; ey = D_VT - 1; sx = S_HT - 1; sy = S_VT - 1;
    evid = 1'b0; svid = 1'b0; els = 1'b0; efs = 1'b0; sls = 1'b0; sfs = 1'b0;
  endtask

  // Called at a negedge; drives one clock and checks at the following negedge.
  task automatic do_step(input logic en);
    logic da, sa;
    pix_en = en;
    vin = 1'($urandom_range(0, 1));
    @(posedge gclk);
    da = (ex < 640) && (ey < 480);
    sa = (sx < 8) && (sy < 6);
    if (en) begin
      evid = vin & da;
      svid = vin & sa;
      ex = (ex == D_HT - 1) ? 0 : ex + 1;
      if (ex == 0) ey = (ey == D_VT - 1) ? 0 : ey + 1;
      sx = (sx == S_HT - 1) ? 0 : sx + 1;
      if (sx == 0) sy = (sy == S_VT - 1) ? 0 : sy + 1;
      els = (ex == 0); efs = (ex == 0) && (ey == 0);
      sls = (sx == 0); sfs = (sx == 0) && (sy == 0);
    end else begin
      els = 1'b0; efs = 1'b0; sls = 1'b0; sfs = 1'b0;
    end
    cyc++;
    @(negedge gclk);
    check_all();
  endtask

  initial begin
    int last_ls, last_fs;
    if (D_HT > 2**D_CW || D_VT > 2**D_CW || S_HT > 2**S_CW || S_VT > 2**S_CW) begin
      $display("FAIL cw_rule totals exceed 2**CW");
      $fatal(1, "illegal parameter combination");
    end

    // reset held, enable already high
    pix_en = 1'b1;
    @(negedge gclk);
    model_reset();
    check_all();
    @(negedge gclk);
    check_all();
    rst = 1'b0;
    do_step(1'b1);              // first step lands on (0,0) with both pulses
    chk("first_fs", 32'(d_fs), 32'd1);

    // continuous run: one full default line plus several tiny frames
    last_ls = -1; last_fs = -1;
    for (int i = 0; i < 1000; i++) begin
      do_step(1'b1);
      if (d_ls) begin
        if (last_ls >= 0) chk("d_ls_period", 32'(cyc - last_ls), 32'd800);
        last_ls = cyc;
      end
      if (s_fs) begin
        if (last_fs >= 0) chk("s_fs_period", 32'(cyc - last_fs), 32'd195);
        last_fs = cyc;
      end
    end
    chk("d_ls_seen", 32'(last_ls >= 0), 32'd1);
    chk("s_fs_seen", 32'(last_fs >= 0), 32'd1);

    // enable toggled 1010...
    for (int i = 0; i < 400; i++) do_step(1'(i % 2 == 0));

`ifdef VGA_LINE_IRQ_EN
    s_irq_line = 5'd20;         // beyond the tiny frame: never fires
    for (int i = 0; i < 400; i++) do_step(1'b1);
    s_irq_line = 5'd3;
`endif

    // asynchronous reset mid-frame, applied between clock edges
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_x", 32'(d_x), 32'(D_HT - 1));
    chk("async_y", 32'(d_y), 32'(D_VT - 1));
    chk("async_sy", 32'(s_y), 32'(S_VT - 1));
    chk("async_active", 32'(d_act), 32'd0);
    @(negedge gclk);
    check_all();
    rst = 1'b0;
    do_step(1'b0);              // disabled step holds the reset position
    do_step(1'b1);
    chk("restart_fs", 32'(d_fs), 32'd1);
    for (int i = 0; i < 300; i++) do_step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
